// File: rtl/cache_lookup_if.sv
// cache_lookup_if: request/response and memory-refill handshakes of cache_lookup_ctrl
interface cache_lookup_if #(parameter int SET_BITS = 3);
  logic req_valid;
  logic req_ready;
  logic [SET_BITS-1:0] req_set;
  logic [23:0] req_tag;
  logic resp_valid;
  logic resp_hit;
  logic [255:0] resp_data;
  logic mem_req;
  logic [23+SET_BITS:0] mem_addr;
  logic mem_ack;
  logic [255:0] mem_rdata;
  modport master (
    output req_valid, req_set, req_tag, mem_ack, mem_rdata,
    input req_ready, resp_valid, resp_hit, resp_data, mem_req, mem_addr
  );
  modport slave (
    input req_valid, req_set, req_tag, mem_ack, mem_rdata,
    output req_ready, resp_valid, resp_hit, resp_data, mem_req, mem_addr
  );
endinterface

// File: rtl/cache_lookup_ctrl.sv
// cache_lookup_ctrl: halt-tag filtered lookup with per-set FIFO refill; CACHE_STATS_EN adds hit/miss counters
module cache_lookup_ctrl #(parameter int SET_BITS = 3) (
  input logic clk,
  input logic reset,
`ifdef CACHE_STATS_EN
  output logic [15:0] stat_hits,
  output logic [15:0] stat_misses,
`endif
  cache_lookup_if.slave bus,
  output logic [2**SET_BITS-1:0] setOut,
  output logic [7:0] decOut1b,
  output logic memWrite,
  output logic inp_viv,
  output logic [23:0] in_tag,
  output logic [255:0] inputData,
  input logic [31:0] outHaltTag,
  input logic out_viv,
  input logic [19:0] outMainTag,
  input logic [255:0] outData
);
  localparam int NSETS = 2**SET_BITS;
  localparam logic [2:0] IDLE = 3'd0, PROBE = 3'd1, MISS_REQ = 3'd2, FILL = 3'd3, RESP = 3'd4;
  logic [2:0] state;
  logic [SET_BITS-1:0] setReg;
  logic [23:0] tagReg;
  logic [7:0] cand, candNow, lowCand, candLeft;
  logic [255:0] lineReg;
  logic hitReg, probeHit;
  logic [2:0] fifoPtr [NSETS];
  always_comb begin
    candNow = '0;
    for (int i = 0; i < 8; i++) candNow[i] = outHaltTag[4*i +: 4] == bus.req_tag[3:0];
  end
  assign lowCand = cand & (~cand + 8'd1);
  assign candLeft = cand & ~lowCand;
  assign probeHit = out_viv && outMainTag == tagReg[23:4];
  assign bus.req_ready = state == IDLE;
  assign bus.resp_valid = state == RESP;
  assign bus.resp_hit = hitReg;
  assign bus.resp_data = lineReg;
  assign bus.mem_req = state == MISS_REQ;
  assign bus.mem_addr = {tagReg, setReg};
  assign memWrite = state == FILL;
  assign inp_viv = memWrite;
  assign in_tag = tagReg;
  assign inputData = lineReg;
  assign setOut = (state == PROBE || state == FILL) ? NSETS'(1) << setReg : '0;
  assign decOut1b = state == PROBE ? lowCand : state == FILL ? 8'(1) << fifoPtr[setReg] : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      setReg <= '0;
      tagReg <= '0;
      cand <= '0;
      lineReg <= '0;
      hitReg <= 1'b0;
      for (int i = 0; i < NSETS; i++) fifoPtr[i] <= '0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          setReg <= bus.req_set;
          tagReg <= bus.req_tag;
          cand <= candNow;
          state <= |candNow ? PROBE : MISS_REQ;
        end
        PROBE: if (probeHit) begin
          lineReg <= outData;
          hitReg <= 1'b1;
          state <= RESP;
        end else begin
          cand <= candLeft;
          if (candLeft == '0) state <= MISS_REQ;
        end
        MISS_REQ: if (bus.mem_ack) begin
          lineReg <= bus.mem_rdata;
          state <= FILL;
        end
        FILL: begin
          fifoPtr[setReg] <= fifoPtr[setReg] + 3'd1;
          hitReg <= 1'b0;
          state <= RESP;
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`ifdef CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_hits <= '0;
      stat_misses <= '0;
    end else if (state == RESP) begin
      if (hitReg && stat_hits != 16'hFFFF) stat_hits <= stat_hits + 16'd1;
      if (!hitReg && stat_misses != 16'hFFFF) stat_misses <= stat_misses + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_cache_lookup_ctrl.sv
// tb_cache_lookup_ctrl: cache_set/memory environment, reference cache model and scoreboard for cache_lookup_ctrl
module tb_cache_lookup_ctrl;
  localparam int SB = 3;
  typedef struct {
    bit hit;
    bit [255:0] data;
    int lat;
    bit [2:0] set;
    bit [2:0] victim;
    bit [23:0] tag;
    bit [7:0] probes;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  cache_lookup_if #(.SET_BITS(SB)) ifc();
  logic [7:0] setOut, decOut1b;
  logic memWrite, inp_viv;
  logic [23:0] in_tag;
  logic [255:0] inputData;
  logic [31:0] outHaltTag;
  logic out_viv;
  logic [19:0] outMainTag;
  logic [255:0] outData;
`ifdef CACHE_STATS_EN
  logic [15:0] stat_hits, stat_misses;
`endif
  cache_lookup_ctrl #(.SET_BITS(SB)) dut (
    .clk(clk),
    .reset(reset),
`ifdef CACHE_STATS_EN
    .stat_hits(stat_hits),
    .stat_misses(stat_misses),
`endif
    .bus(ifc),
    .setOut(setOut),
    .decOut1b(decOut1b),
    .memWrite(memWrite),
    .inp_viv(inp_viv),
    .in_tag(in_tag),
    .inputData(inputData),
    .outHaltTag(outHaltTag),
    .out_viv(out_viv),
    .outMainTag(outMainTag),
    .outData(outData)
  );
  bit envValid [8][8];
  bit [23:0] envTag [8][8];
  bit [255:0] envData [8][8];
  bit refValid [8][8];
  bit [23:0] refTag [8][8];
  bit [255:0] refData [8][8];
  int refPtr [8];
  exp_t expQ [$];
  exp_t em;
  int checks = 0, errors = 0, expHit = 0, expMiss = 0;
  int cyc = 0, accCyc = 0, memDelay = -1;
  bit memAuto = 1, useFixed = 0, memSeen = 0, started = 0;
  bit [255:0] fixedLine = '0;
  bit [7:0] left = '0;
  bit plEn = 0, plValid = 0;
  bit [2:0] plS = 0, plW = 0;
  bit [23:0] plTag = 0;
  bit [255:0] plData = 0;
  function automatic logic [255:0] memLine(input logic [26:0] a);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = {5'(i), a} ^ 32'h5A5A_3C3C;
    return r;
  endfunction
  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask
  // the cache_set array seen by the controller: halt tags of the requested set, selected way via one-hots
  always_comb begin
    outHaltTag = '0;
    out_viv = 1'b0;
    outMainTag = '0;
    outData = '0;
    for (int w = 0; w < 8; w++) outHaltTag[4*w +: 4] = envTag[ifc.req_set][w][3:0];
    for (int s = 0; s < 8; s++)
      for (int w = 0; w < 8; w++)
        if (setOut[s] && decOut1b[w]) begin
          out_viv = envValid[s][w];
          outMainTag = envTag[s][w][23:4];
          outData = envData[s][w];
        end
  end
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset && ifc.req_valid && ifc.req_ready) accCyc <= cyc;
    if (plEn) begin
      envValid[plS][plW] <= plValid;
      envTag[plS][plW] <= plTag;
      envData[plS][plW] <= plData;
    end
    if (memWrite)
      for (int s = 0; s < 8; s++)
        for (int w = 0; w < 8; w++)
          if (setOut[s] && decOut1b[w]) begin
            envValid[s][w] <= inp_viv;
            envTag[s][w] <= in_tag;
            envData[s][w] <= inputData;
          end
  end
  initial begin
    ifc.mem_ack = 1'b0;
    ifc.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (memAuto && ifc.mem_req) begin
        repeat (memDelay < 0 ? $urandom_range(0, 3) : memDelay) @(posedge clk);
        #1;
        ifc.mem_ack = 1'b1;
        ifc.mem_rdata = useFixed ? fixedLine : memLine(ifc.mem_addr);
        @(posedge clk);
        #1;
        ifc.mem_ack = 1'b0;
        ifc.mem_rdata = 256'($urandom);
      end
    end
  end
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        memSeen = 0;
        started = 0;
      end else begin
        if (ifc.mem_req) memSeen = 1;
        if (decOut1b != 0 && !memWrite) begin
          chk("probe_expected", expQ.size() != 0, 1);
          if (expQ.size() != 0) begin
            if (!started) begin
              left = expQ[0].probes;
              started = 1;
            end
            chk("probe_way", decOut1b, left & (~left + 8'd1));
            chk("probe_set", setOut, 8'(1) << expQ[0].set);
            left = left & ~decOut1b;
          end
        end
        if (memWrite) begin
          chk("write_expected", expQ.size() != 0, 1);
          if (expQ.size() != 0) begin
            em = expQ[0];
            chk("write_on_miss_only", em.hit, 0);
            chk("write_victim_way", decOut1b, 8'(1) << em.victim);
            chk("write_set", setOut, 8'(1) << em.set);
            chk("write_tag", in_tag, em.tag);
            chk("write_data", inputData, em.data);
            chk("write_viv", inp_viv, 1);
          end
        end
        if (ifc.resp_valid) begin
          chk("resp_expected", expQ.size() != 0, 1);
          if (expQ.size() != 0) begin
            em = expQ.pop_front();
            if (!started) left = em.probes;
            chk("all_candidates_probed", left, 0);
            chk("resp_hit", ifc.resp_hit, em.hit);
            chk("resp_data", ifc.resp_data, em.data);
            if (em.hit) begin
              chk("hit_latency", cyc - accCyc, em.lat);
              chk("hit_without_mem_req", memSeen, 0);
            end
          end
          started = 0;
          memSeen = 0;
        end
      end
    end
  end
  task automatic preload(input bit [2:0] s, input bit [2:0] w, input bit [23:0] t, input bit v, input bit [255:0] d);
    refValid[s][w] = v;
    refTag[s][w] = t;
    refData[s][w] = d;
    plS = s;
    plW = w;
    plTag = t;
    plValid = v;
    plData = d;
    plEn = 1;
    @(posedge clk);
    #1;
    plEn = 0;
  endtask
  task automatic waitReady();
    int n = 0;
    while (!ifc.req_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) chk("req_ready_timeout", ifc.req_ready, 1);
  endtask
  // reference: a hit is any valid line with the full tag; candidates are probed lowest way first
  task automatic issue(input bit [2:0] s, input bit [23:0] t);
    exp_t e;
    int k = 0, n = 0;
    bit found = 0;
    e.set = s;
    e.tag = t;
    e.probes = '0;
    e.hit = 0;
    e.lat = 0;
    e.victim = '0;
    e.data = '0;
    for (int w = 0; w < 8; w++)
      if (!found && refTag[s][w][3:0] == t[3:0]) begin
        e.probes[w] = 1'b1;
        k++;
        if (refValid[s][w] && refTag[s][w] == t) begin
          found = 1;
          e.hit = 1;
          e.data = refData[s][w];
          e.lat = 1 + k;
        end
      end
    if (found) expHit++;
    else begin
      expMiss++;
      e.victim = 3'(refPtr[s]);
      e.data = useFixed ? fixedLine : memLine({t, s});
      refValid[s][refPtr[s]] = 1;
      refTag[s][refPtr[s]] = t;
      refData[s][refPtr[s]] = e.data;
      refPtr[s] = (refPtr[s] + 1) % 8;
    end
    waitReady();
    expQ.push_back(e);
    ifc.req_valid = 1'b1;
    ifc.req_set = s;
    ifc.req_tag = t;
    @(posedge clk);
    #1;
    ifc.req_valid = 1'b0;
    ifc.req_tag = 24'($urandom);
    while (expQ.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("resp_timeout", expQ.size() == 0, 1);
    expQ.delete();
  endtask
  initial begin
    int n;
    ifc.req_valid = 1'b0;
    ifc.req_set = '0;
    ifc.req_tag = '0;
    for (int s = 0; s < 8; s++) refPtr[s] = 0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_req_ready", ifc.req_ready, 1);
    chk("reset_mem_req", ifc.mem_req, 0);
    chk("reset_memWrite", memWrite, 0);
    chk("reset_decOut1b", decOut1b, 0);
    chk("reset_setOut", setOut, 0);
    chk("reset_resp_valid", ifc.resp_valid, 0);
`ifdef CACHE_STATS_EN
    chk("reset_stat_hits", stat_hits, 0);
    chk("reset_stat_misses", stat_misses, 0);
`endif
    useFixed = 1;
    fixedLine = 256'h1234;
    memDelay = 3;
    issue(3'd2, 24'hABCDE5);
    useFixed = 0;
    memDelay = -1;
    issue(3'd2, 24'hABCDE5);
    for (int w = 0; w < 8; w++)
      preload(3'd3, 3'(w), w == 1 ? 24'h111115 : w == 5 ? 24'h555555 : {20'(w + 32), 4'hA}, 1, 256'(w * 7 + 1));
    issue(3'd3, 24'h555555);
    preload(3'd6, 3'd2, 24'h777772, 0, 256'hDEAD);
    issue(3'd6, 24'h777772);
    issue(3'd6, 24'h777772);
    for (int i = 0; i < 9; i++) issue(3'd0, {20'(i + 100), 4'hC});
    issue(3'd1, 24'h000010);
    memAuto = 0;
    waitReady();
    ifc.req_valid = 1'b1;
    ifc.req_set = 3'd4;
    ifc.req_tag = 24'hFEDCB7;
    @(posedge clk);
    #1;
    ifc.req_valid = 1'b0;
    n = 0;
    while (!ifc.mem_req && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("mem_req_before_reset", ifc.mem_req, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("mem_req_cleared_by_reset", ifc.mem_req, 0);
    chk("ready_after_reset", ifc.req_ready, 1);
    for (int s = 0; s < 8; s++) refPtr[s] = 0;
    expHit = 0;
    expMiss = 0;
    ifc.mem_ack = 1'b1;
    ifc.mem_rdata = 256'hBAD;
    @(posedge clk);
    #1;
    ifc.mem_ack = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("late_ack_ignored", ifc.mem_req | memWrite | ifc.resp_valid, 0);
    memAuto = 1;
    repeat (300) begin
      issue(3'($urandom_range(0, 7)), {20'hC0000 + 20'($urandom_range(0, 5)), 4'($urandom_range(0, 3))});
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
`ifdef CACHE_STATS_EN
    chk("stat_hits", stat_hits, expHit);
    chk("stat_misses", stat_misses, expMiss);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
